alu_issue: RTL and testbench

Single-issue front end that sits directly upstream of the `alu` inside `cpu`. It accepts 16-bit instruction words over a valid/ready handshake, reads operands from a 4-entry register file, and drives the ALU's `instr_i`, `a_i`, `b_i` and `cin_i` inputs from registered operand latches. One cycle later it captures the ALU's `acc_o` and `cout_o` into the destination register and the carry flag. It replaces the free-floating `r1`/`r2`/`r3`/`f1` registers in `cpu` with a sequenced register file and flag.

---
 rtl/alu_issue.sv | 157 +++++++++++++++
 tb/tb_alu_issue.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue ALU front end with 4-entry register file and carry flag
//
// Purpose:
//   Accepts 16-bit instruction words, reads two operands from a 4-entry
//   register file, drives them to a downstream combinational ALU from
//   registered latches, and writes the ALU result and carry back one cycle
//   later. A side load port writes registers directly while idle.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   instr_valid_i / instr_ready_o   instruction handshake
//   instr_i[15:0]                   {opcode, rd, ra, rb, use_carry, 5'bx}
//   ld_valid_i / ld_ready_o         register load handshake
//   ld_addr_i, ld_data_i            load destination and data
//   alu_instr_o, alu_a_o, alu_b_o,
//   alu_cin_o                       registered ALU operand drives
//   alu_acc_i, alu_cout_i           ALU result and carry out
//   wb_valid_o                      writeback happening this cycle
//   carry_o                         current carry flag
//   dbg_addr_i / dbg_data_o         combinational register read

module alu_issue #(
   parameter int REG_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid_i,
   output logic                 instr_ready_o,
   input  logic [15:0]          instr_i,
   input  logic                 ld_valid_i,
   output logic                 ld_ready_o,
   input  logic [1:0]           ld_addr_i,
   input  logic [REG_WIDTH-1:0] ld_data_i,
   output logic [3:0]           alu_instr_o,
   output logic [REG_WIDTH-1:0] alu_a_o,
   output logic [REG_WIDTH-1:0] alu_b_o,
   output logic                 alu_cin_o,
   input  logic [REG_WIDTH-1:0] alu_acc_i,
   input  logic                 alu_cout_i,
   output logic                 wb_valid_o,
   output logic                 carry_o,
   input  logic [1:0]           dbg_addr_i,
   output logic [REG_WIDTH-1:0] dbg_data_o
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [REG_WIDTH-1:0] regs_q [4];
   logic [REG_WIDTH-1:0] regs_d [4];
   logic                 carry_q, carry_d;
   logic [1:0]           rd_q, rd_d;
   logic [3:0]           alu_instr_q, alu_instr_d;
   logic [REG_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [REG_WIDTH-1:0] alu_b_q, alu_b_d;
   logic                 alu_cin_q, alu_cin_d;

   // Instruction field decode
   logic [3:0] op_opcode;
   logic [1:0] op_rd;
   logic [1:0] op_ra;
   logic [1:0] op_rb;
   logic       op_use_carry;
   logic       unused_instr_bits;

   assign op_opcode         = instr_i[15:12];
   assign op_rd             = instr_i[11:10];
   assign op_ra             = instr_i[9:8];
   assign op_rb             = instr_i[7:6];
   assign op_use_carry      = instr_i[5];
   assign unused_instr_bits = ^instr_i[4:0];

   logic instr_accept;

   // Readies depend only on state and ld_valid_i; a pending load blocks
   // instruction accept so the two never race for the register file.
   always_comb begin
      ld_ready_o    = (state_q == IDLE);
      instr_ready_o = (state_q == IDLE) && !ld_valid_i;
      wb_valid_o    = (state_q == EXEC);
      instr_accept  = instr_valid_i && instr_ready_o;
   end

   always_comb begin
      state_d     = state_q;
      regs_d      = regs_q;
      carry_d     = carry_q;
      rd_d        = rd_q;
      alu_instr_d = alu_instr_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_cin_d   = alu_cin_q;

      case (state_q)
         IDLE: begin
            if (ld_valid_i) begin
               regs_d[ld_addr_i] = ld_data_i;
            end else if (instr_accept) begin
               // Operands are captured here, so rd aliasing ra/rb reads the
               // pre-writeback value.
               alu_instr_d = op_opcode;
               alu_a_d     = regs_q[op_ra];
               alu_b_d     = regs_q[op_rb];
               alu_cin_d   = op_use_carry ? carry_q : 1'b0;
               rd_d        = op_rd;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            regs_d[rd_q] = alu_acc_i;
            carry_d      = alu_cout_i;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset wins over everything, including an in-flight writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
         carry_q     <= 1'b0;
         rd_q        <= 2'd0;
         alu_instr_q <= 4'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_cin_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         carry_q     <= carry_d;
         rd_q        <= rd_d;
         alu_instr_q <= alu_instr_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_cin_q   <= alu_cin_d;
      end
   end

   assign alu_instr_o = alu_instr_q;
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_cin_o   = alu_cin_q;
   assign carry_o     = carry_q;
   assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue

module tb_alu_issue;

   logic        clk;
   logic        reset;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [15:0] instr_i;
   logic        ld_valid_i;
   logic        ld_ready_o;
   logic [1:0]  ld_addr_i;
   logic [15:0] ld_data_i;
   logic [3:0]  alu_instr_o;
   logic [15:0] alu_a_o;
   logic [15:0] alu_b_o;
   logic        alu_cin_o;
   logic [15:0] alu_acc_i;
   logic        alu_cout_i;
   logic        wb_valid_o;
   logic        carry_o;
   logic [1:0]  dbg_addr_i;
   logic [15:0] dbg_data_o;

   int n_checks;
   int n_fail;

   alu_issue #(.REG_WIDTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_valid_i(instr_valid_i),
      .instr_ready_o(instr_ready_o),
      .instr_i      (instr_i),
      .ld_valid_i   (ld_valid_i),
      .ld_ready_o   (ld_ready_o),
      .ld_addr_i    (ld_addr_i),
      .ld_data_i    (ld_data_i),
      .alu_instr_o  (alu_instr_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_cin_o    (alu_cin_o),
      .alu_acc_i    (alu_acc_i),
      .alu_cout_i   (alu_cout_i),
      .wb_valid_o   (wb_valid_o),
      .carry_o      (carry_o),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_data_o   (dbg_data_o)
   );

   // ALU stub: acc = a + b + cin, cout = carry out of that sum
   logic [16:0] alu_sum;
   assign alu_sum    = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {16'd0, alu_cin_o};
   assign alu_acc_i  = alu_sum[15:0];
   assign alu_cout_i = alu_sum[16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic uc);
      return {op, rd, ra, rb, uc, 5'b00000};
   endfunction

   task automatic read_reg(input logic [1:0] a, output logic [15:0] v);
      dbg_addr_i = a;
      #1;
      v = dbg_data_o;
   endtask

   task automatic do_load(input logic [1:0] a, input logic [15:0] d);
      ld_valid_i = 1'b1;
      ld_addr_i  = a;
      ld_data_i  = d;
      tick();
      ld_valid_i = 1'b0;
   endtask

   // Issues one instruction from IDLE and reports what was seen on the ALU
   // side during the EXEC cycle.
   task automatic issue(input logic [15:0] word, output logic rdy_before,
                        output logic wb_exec, output logic [15:0] a_seen,
                        output logic [15:0] b_seen, output logic cin_seen,
                        output logic wb_after);
      instr_i       = word;
      instr_valid_i = 1'b1;
      #1;
      rdy_before = instr_ready_o;
      tick();
      instr_valid_i = 1'b0;
      #1;
      wb_exec  = wb_valid_o;
      a_seen   = alu_a_o;
      b_seen   = alu_b_o;
      cin_seen = alu_cin_o;
      tick();
      wb_after = wb_valid_o;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         read_reg(i[1:0], v);
         n_checks++;
         if (v !== 16'h0000) begin
            $display("FAIL reset_reg%0d actual=%h required=0000", i, v);
            n_fail++;
         end
      end
      n_checks++;
      if (carry_o !== 1'b0) begin
         $display("FAIL reset_carry actual=%b required=0", carry_o);
         n_fail++;
      end
      n_checks++;
      if (instr_ready_o !== 1'b1) begin
         $display("FAIL reset_instr_ready actual=%b required=1", instr_ready_o);
         n_fail++;
      end
      n_checks++;
      if (wb_valid_o !== 1'b0) begin
         $display("FAIL reset_wb_valid actual=%b required=0", wb_valid_o);
         n_fail++;
      end
      n_checks++;
      if ({alu_instr_o, alu_a_o, alu_b_o, alu_cin_o} !== 37'd0) begin
         $display("FAIL reset_alu_outs actual=%h/%h/%h/%b required=0", alu_instr_o, alu_a_o, alu_b_o, alu_cin_o);
         n_fail++;
      end
   endtask

   task automatic test_basic_add();
      logic rdy, wbe, wba, cin;
      logic [15:0] a, b, v;
      do_load(2'd0, 16'h0005);
      do_load(2'd1, 16'h0003);
      issue(enc(4'h1, 2'd2, 2'd0, 2'd1, 1'b0), rdy, wbe, a, b, cin, wba);
      n_checks++;
      if (rdy !== 1'b1) begin
         $display("FAIL add_ready actual=%b required=1", rdy);
         n_fail++;
      end
      n_checks++;
      if (a !== 16'h0005 || b !== 16'h0003) begin
         $display("FAIL add_operands actual=%h,%h required=0005,0003", a, b);
         n_fail++;
      end
      n_checks++;
      if (wbe !== 1'b1 || wba !== 1'b0) begin
         $display("FAIL add_wb_pulse actual=%b%b required=10", wbe, wba);
         n_fail++;
      end
      read_reg(2'd2, v);
      n_checks++;
      if (v !== 16'h0008 || carry_o !== 1'b0) begin
         $display("FAIL add_result actual=%h c=%b required=0008 c=0", v, carry_o);
         n_fail++;
      end
      n_checks++;
      if (alu_a_o !== 16'h0005 || alu_instr_o !== 4'h1) begin
         $display("FAIL add_hold_operands actual=%h op=%h required=0005 op=1", alu_a_o, alu_instr_o);
         n_fail++;
      end
   endtask

   task automatic test_carry_chain();
      logic rdy, wbe, wba, cin;
      logic [15:0] a, b, v;
      do_load(2'd0, 16'hFFFF);
      do_load(2'd1, 16'h0001);
      issue(enc(4'h2, 2'd2, 2'd0, 2'd1, 1'b0), rdy, wbe, a, b, cin, wba);
      read_reg(2'd2, v);
      n_checks++;
      if (v !== 16'h0000 || carry_o !== 1'b1) begin
         $display("FAIL carry_wrap actual=%h c=%b required=0000 c=1", v, carry_o);
         n_fail++;
      end
      issue(enc(4'h2, 2'd3, 2'd1, 2'd1, 1'b1), rdy, wbe, a, b, cin, wba);
      n_checks++;
      if (cin !== 1'b1) begin
         $display("FAIL carry_cin actual=%b required=1", cin);
         n_fail++;
      end
      read_reg(2'd3, v);
      n_checks++;
      if (v !== 16'h0003 || carry_o !== 1'b0) begin
         $display("FAIL carry_use actual=%h c=%b required=0003 c=0", v, carry_o);
         n_fail++;
      end
   endtask

   task automatic test_priority();
      logic [15:0] v;
      // load r3 and instruction r1 = r3 + r3 presented together
      ld_valid_i    = 1'b1;
      ld_addr_i     = 2'd3;
      ld_data_i     = 16'h00AA;
      instr_i       = enc(4'h3, 2'd1, 2'd3, 2'd3, 1'b0);
      instr_valid_i = 1'b1;
      #1;
      n_checks++;
      if (instr_ready_o !== 1'b0 || ld_ready_o !== 1'b1) begin
         $display("FAIL prio_readies actual=i%b l%b required=i0 l1", instr_ready_o, ld_ready_o);
         n_fail++;
      end
      tick();
      ld_valid_i = 1'b0;
      read_reg(2'd3, v);
      n_checks++;
      if (v !== 16'h00AA || instr_ready_o !== 1'b1) begin
         $display("FAIL prio_load_first actual=%h rdy=%b required=00aa rdy=1", v, instr_ready_o);
         n_fail++;
      end
      tick();
      instr_valid_i = 1'b0;
      ld_valid_i    = 1'b1;
      ld_addr_i     = 2'd0;
      ld_data_i     = 16'h1234;
      #1;
      n_checks++;
      if (wb_valid_o !== 1'b1 || alu_a_o !== 16'h00AA || ld_ready_o !== 1'b0 || instr_ready_o !== 1'b0) begin
         $display("FAIL prio_exec actual=wb%b a=%h l%b i%b required=wb1 a=00aa l0 i0", wb_valid_o, alu_a_o, ld_ready_o, instr_ready_o);
         n_fail++;
      end
      tick();
      read_reg(2'd0, v);
      n_checks++;
      if (v !== 16'hFFFF || ld_ready_o !== 1'b1) begin
         $display("FAIL prio_ld_held actual=%h l%b required=ffff l1", v, ld_ready_o);
         n_fail++;
      end
      read_reg(2'd1, v);
      n_checks++;
      if (v !== 16'h0154 || carry_o !== 1'b0) begin
         $display("FAIL prio_result actual=%h c=%b required=0154 c=0", v, carry_o);
         n_fail++;
      end
      tick();
      ld_valid_i = 1'b0;
      read_reg(2'd0, v);
      n_checks++;
      if (v !== 16'h1234) begin
         $display("FAIL prio_ld_applied actual=%h required=1234", v);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      do_load(2'd0, 16'h0002);
      instr_i       = enc(4'h4, 2'd0, 2'd0, 2'd0, 1'b0);
      instr_valid_i = 1'b1;
      tick();
      n_checks++;
      if (wb_valid_o !== 1'b1 || instr_ready_o !== 1'b0 || alu_a_o !== 16'h0002) begin
         $display("FAIL b2b_exec1 actual=wb%b i%b a=%h required=wb1 i0 a=0002", wb_valid_o, instr_ready_o, alu_a_o);
         n_fail++;
      end
      tick();
      read_reg(2'd0, v);
      n_checks++;
      if (v !== 16'h0004 || instr_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
         $display("FAIL b2b_idle actual=%h i%b wb%b required=0004 i1 wb0", v, instr_ready_o, wb_valid_o);
         n_fail++;
      end
      tick();
      instr_valid_i = 1'b0;
      #1;
      n_checks++;
      if (wb_valid_o !== 1'b1 || alu_a_o !== 16'h0004 || alu_b_o !== 16'h0004) begin
         $display("FAIL b2b_exec2 actual=wb%b a=%h b=%h required=wb1 a=0004 b=0004", wb_valid_o, alu_a_o, alu_b_o);
         n_fail++;
      end
      tick();
      read_reg(2'd0, v);
      n_checks++;
      if (v !== 16'h0008) begin
         $display("FAIL b2b_result actual=%h required=0008", v);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [15:0] v;
      logic rdy, wbe, wba, cin;
      logic [15:0] a, b;
      // set carry to 1 first so the reset's clearing is observable
      do_load(2'd1, 16'h8000);
      issue(enc(4'h5, 2'd2, 2'd1, 2'd1, 1'b0), rdy, wbe, a, b, cin, wba);
      n_checks++;
      if (carry_o !== 1'b1) begin
         $display("FAIL rst_exec_setup actual=%b required=1", carry_o);
         n_fail++;
      end
      do_load(2'd1, 16'h0005);
      instr_i       = enc(4'h6, 2'd3, 2'd1, 2'd1, 1'b1);
      instr_valid_i = 1'b1;
      tick();
      instr_valid_i = 1'b0;
      reset         = 1'b1;
      tick();
      reset = 1'b0;
      read_reg(2'd3, v);
      n_checks++;
      if (v !== 16'h0000 || carry_o !== 1'b0) begin
         $display("FAIL rst_exec_wb actual=%h c=%b required=0000 c=0", v, carry_o);
         n_fail++;
      end
      n_checks++;
      if (wb_valid_o !== 1'b0 || instr_ready_o !== 1'b1 || ld_ready_o !== 1'b1) begin
         $display("FAIL rst_exec_idle actual=wb%b i%b l%b required=wb0 i1 l1", wb_valid_o, instr_ready_o, ld_ready_o);
         n_fail++;
      end
      n_checks++;
      if ({alu_instr_o, alu_a_o, alu_b_o, alu_cin_o} !== 37'd0) begin
         $display("FAIL rst_exec_alu actual=%h/%h/%h/%b required=0", alu_instr_o, alu_a_o, alu_b_o, alu_cin_o);
         n_fail++;
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b0;
      instr_valid_i = 1'b0;
      instr_i       = 16'h0000;
      ld_valid_i    = 1'b0;
      ld_addr_i     = 2'd0;
      ld_data_i     = 16'h0000;
      dbg_addr_i    = 2'd0;
      test_reset();
      test_basic_add();
      test_carry_chain();
      test_priority();
      test_back_to_back();
      test_reset_mid_exec();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
